brightness_control_ctrl: RTL
============================

BRIGHTNESS_CONTROL_CTRL -- requirements
Module: brightness_control_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning stream data bus width.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning bits per colour plane.
REQ-003 SHALL have parameter DATA_PLANES, default 1, legal values 1..3, meaning planes per beat.
REQ-004 SHALL have ports, one per line:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- av_address  in  3  register address.
- av_write / av_read  in  1 each  register write / read strobes.
- av_writedata  in  32  write data.
- av_readdata  out  32  read data.
- mon_data  in  DATA_WIDTH  snooped stream data.
- mon_valid / mon_ready  in  1 each  snooped stream handshake.
- mon_sop / mon_eop  in  1 each  snooped packet delimiters.
- video_width / video_height  out  16 each  decoded frame size.
- video_interlaced  out  4  decoded interlace nibble.
- bc_offset  out  DATA_BITS+1  active signed brightness offset.
- bc_enable  out  1  active datapath enable.
- irq  out  1  end-of-frame interrupt.

Function
REQ-005 SHALL treat a beat as accepted only when mon_valid & mon_ready; all other cycles SHALL leave state unchanged.
REQ-006 Parser FSM SHALL have states IDLE, CTRL, VIDEO, SKIP; reset state IDLE.
REQ-007 On an accepted sop beat in any state, mon_data[3:0]==0xF SHALL go to CTRL, 0x0 to VIDEO, other values to SKIP; the sop beat resynchronises the parse.
REQ-008 In CTRL, plane k of each accepted beat SHALL supply nibble mon_data[DATA_BITS*k+3:DATA_BITS*k], k=0..DATA_PLANES-1 in ascending order. Nibbles 0..8 SHALL be width[15:12..3:0], height[15:12..3:0], interlaced.
REQ-009 On the eop beat of CTRL, if at least 9 nibbles were collected, nibbles SHALL commit to video_width/height/interlaced on the next edge. Otherwise the packet SHALL be discarded and the outputs held. Nibbles beyond 9 SHALL be ignored.
REQ-010 An accepted VIDEO sop beat SHALL copy shadow OFFSET to bc_offset and CTRL.go to bc_enable on the next edge. There SHALL be no other update path.
REQ-011 A register write coinciding with the commit edge SHALL update the shadow only; the commit SHALL use the pre-write shadow value.
REQ-012 An accepted VIDEO eop beat SHALL increment FRAME_CNT (16 bit, 0xFFFF wraps to 0), set STATUS.irq_pend, and return to IDLE. An eop beat in CTRL or SKIP SHALL return to IDLE.
REQ-013 Register map:
- 0 CTRL rw: bit0 go, bit1 irq_en.
- 1 STATUS: bit0 running=bc_enable (ro), bit1 irq_pend (write-1-clear).
- 2 OFFSET rw: [DATA_BITS:0] signed shadow.
- 3 WIDTH ro.
- 4 HEIGHT ro.
- 5 INTERLACED ro.
- 6 FRAME_CNT ro; any write clears it.
- 7 reads 0.
Unused bits SHALL read 0.
REQ-014 av_readdata SHALL be registered, valid one cycle after av_read, and held otherwise.
REQ-015 If irq_pend set and W1C occur in the same cycle, set SHALL win.
REQ-016 irq SHALL equal irq_pend & irq_en.

Reset
REQ-017 rst_n low SHALL asynchronously clear all registers and outputs to 0, including mid-packet; the parse SHALL restart at IDLE and wait for the next sop.

Configuration
REQ-018 With macro BRIGHTNESS_CONTROL_IRQ_EN defined, irq, irq_en and irq_pend SHALL exist per REQ-012/015/016.
REQ-019 Without BRIGHTNESS_CONTROL_IRQ_EN, irq SHALL be tied 0, and CTRL bit1 and STATUS bit1 SHALL read 0 and ignore writes.

Structure
REQ-020 Package brightness_control_pkg SHALL hold: parser state encodings, register address constants, packet-type constants (CTRL_PKT=0xF, VIDEO_PKT=0x0), and the nibble count 9.
REQ-021 Sub-module brightness_control_pkt_parser SHALL contain the parser FSM and nibble collector. The top level SHALL hold the registers, commit logic and interrupt.

Verification
REQ-022 DATA_PLANES=1: control packet F,0,2,8,0,0,1,E,0,3 then video sop -> WIDTH=0x0280, HEIGHT=0x01E0, INTERLACED=3.
REQ-023 DATA_PLANES=3: control packet of 4 beats carrying the same values -> identical WIDTH/HEIGHT/INTERLACED. A 3-beat variant -> discarded, previous values held.
REQ-024 Write OFFSET=-16 mid-frame -> bc_offset unchanged until the next video sop, then 0x1F0 (9-bit).
REQ-025 go=1 and irq_en=1, then a 2-beat video packet -> FRAME_CNT=1, irq=1. Write STATUS=0x2 -> irq=0. W1C on the same cycle as eop -> irq stays 1.
REQ-026 Assert rst_n low mid control packet, then release and send video sop -> WIDTH=0, bc_enable=0. mon_valid=1 with mon_ready=0 -> no state change.

Source files
------------

// File: rtl/brightness_control_pkg.sv
// Shared definitions for the brightness control block: parser states,
// register map, packet types and control-packet nibble count.
package brightness_control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CTRL  = 2'd1,
    ST_VIDEO = 2'd2,
    ST_SKIP  = 2'd3
  } parse_state_t;

  localparam logic [2:0] ADDR_CTRL       = 3'd0;
  localparam logic [2:0] ADDR_STATUS     = 3'd1;
  localparam logic [2:0] ADDR_OFFSET     = 3'd2;
  localparam logic [2:0] ADDR_WIDTH      = 3'd3;
  localparam logic [2:0] ADDR_HEIGHT     = 3'd4;
  localparam logic [2:0] ADDR_INTERLACED = 3'd5;
  localparam logic [2:0] ADDR_FRAME_CNT  = 3'd6;

  localparam logic [3:0] CTRL_PKT  = 4'hF;
  localparam logic [3:0] VIDEO_PKT = 4'h0;

  localparam logic [3:0] NIBBLE_COUNT = 4'd9;

endpackage

// File: rtl/brightness_control_pkt_parser.sv
// Snooped-stream packet parser: classifies packets on sop and collects the
// width/height/interlace nibbles of control packets.
module brightness_control_pkt_parser
  import brightness_control_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned DATA_PLANES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] mon_data,
  input  logic                  mon_valid,
  input  logic                  mon_ready,
  input  logic                  mon_sop,
  input  logic                  mon_eop,
  output logic                  ctrl_commit,
  output logic [15:0]           fmt_width,
  output logic [15:0]           fmt_height,
  output logic [3:0]            fmt_interlaced,
  output logic                  video_sop,
  output logic                  video_eop
);

  parse_state_t state, state_next;
  logic [NIBBLE_COUNT-1:0][3:0] nib, nib_next;
  logic [3:0] cnt, cnt_next;
  logic       beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      nib   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      nib   <= nib_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    beat        = mon_valid & mon_ready;
    state_next  = state;
    nib_next    = nib;
    cnt_next    = cnt;
    ctrl_commit = 1'b0;
    video_sop   = 1'b0;
    video_eop   = 1'b0;
    if (beat) begin
      if (mon_sop) begin
        cnt_next = '0;
        if (mon_data[3:0] == CTRL_PKT) begin
          state_next = ST_CTRL;
        end else if (mon_data[3:0] == VIDEO_PKT) begin
          state_next = ST_VIDEO;
          video_sop  = 1'b1;
        end else begin
          state_next = ST_SKIP;
        end
        // A single-beat packet ends where it starts; control packets carry no nibbles on sop.
        if (mon_eop) begin
          video_eop  = (mon_data[3:0] == VIDEO_PKT);
          state_next = ST_IDLE;
        end
      end else begin
        unique case (state)
          ST_CTRL: begin
            for (int unsigned k = 0; k < DATA_PLANES; k++) begin
              if (cnt_next < NIBBLE_COUNT) begin
                nib_next[cnt_next] = mon_data[DATA_BITS*k +: 4];
                cnt_next           = cnt_next + 4'd1;
              end
            end
            if (mon_eop) begin
              ctrl_commit = (cnt_next == NIBBLE_COUNT);
              state_next  = ST_IDLE;
            end
          end
          ST_VIDEO: begin
            if (mon_eop) begin
              video_eop  = 1'b1;
              state_next = ST_IDLE;
            end
          end
          ST_SKIP: begin
            if (mon_eop) state_next = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs include the current beat's nibbles so the commit lands on the eop edge.
  assign fmt_width      = {nib_next[0], nib_next[1], nib_next[2], nib_next[3]};
  assign fmt_height     = {nib_next[4], nib_next[5], nib_next[6], nib_next[7]};
  assign fmt_interlaced = nib_next[8];

endmodule

// File: rtl/brightness_control_ctrl.sv
// Brightness control register block: stream snooping, shadowed offset/enable
// applied on video sop, frame counter. Interrupt logic under BRIGHTNESS_CONTROL_IRQ_EN.
module brightness_control_ctrl
  import brightness_control_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned DATA_PLANES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            av_address,
  input  logic                  av_write,
  input  logic                  av_read,
  input  logic [31:0]           av_writedata,
  output logic [31:0]           av_readdata,
  input  logic [DATA_WIDTH-1:0] mon_data,
  input  logic                  mon_valid,
  input  logic                  mon_ready,
  input  logic                  mon_sop,
  input  logic                  mon_eop,
  output logic [15:0]           video_width,
  output logic [15:0]           video_height,
  output logic [3:0]            video_interlaced,
  output logic [DATA_BITS:0]    bc_offset,
  output logic                  bc_enable,
  output logic                  irq
);

  logic              ctrl_commit, video_sop, video_eop;
  logic [15:0]       fmt_width, fmt_height;
  logic [3:0]        fmt_interlaced;
  logic              ctrl_go, irq_en, irq_pend;
  logic [DATA_BITS:0] offset_shadow;
  logic [15:0]       frame_cnt;
  logic [31:0]       rd_data;
  logic              wr_ctrl, wr_status, wr_offset, wr_frame;
  logic              unused_wd;

  brightness_control_pkt_parser #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_BITS  (DATA_BITS),
    .DATA_PLANES(DATA_PLANES)
  ) u_parser (
    .clk           (clk),
    .rst_n         (rst_n),
    .mon_data      (mon_data),
    .mon_valid     (mon_valid),
    .mon_ready     (mon_ready),
    .mon_sop       (mon_sop),
    .mon_eop       (mon_eop),
    .ctrl_commit   (ctrl_commit),
    .fmt_width     (fmt_width),
    .fmt_height    (fmt_height),
    .fmt_interlaced(fmt_interlaced),
    .video_sop     (video_sop),
    .video_eop     (video_eop)
  );

  assign wr_ctrl   = av_write && (av_address == ADDR_CTRL);
  assign wr_status = av_write && (av_address == ADDR_STATUS);
  assign wr_offset = av_write && (av_address == ADDR_OFFSET);
  assign wr_frame  = av_write && (av_address == ADDR_FRAME_CNT);
  assign unused_wd = ^av_writedata;

  // Non-blocking reads of ctrl_go/offset_shadow give the pre-write value on a coinciding write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_go          <= 1'b0;
      offset_shadow    <= '0;
      video_width      <= '0;
      video_height     <= '0;
      video_interlaced <= '0;
      bc_offset        <= '0;
      bc_enable        <= 1'b0;
      frame_cnt        <= '0;
      av_readdata      <= '0;
    end else begin
      if (wr_ctrl)   ctrl_go       <= av_writedata[0];
      if (wr_offset) offset_shadow <= av_writedata[DATA_BITS:0];
      if (ctrl_commit) begin
        video_width      <= fmt_width;
        video_height     <= fmt_height;
        video_interlaced <= fmt_interlaced;
      end
      if (video_sop) begin
        bc_offset <= offset_shadow;
        bc_enable <= ctrl_go;
      end
      if (wr_frame)       frame_cnt <= '0;
      else if (video_eop) frame_cnt <= frame_cnt + 16'd1;
      if (av_read) av_readdata <= rd_data;
    end
  end

`ifdef BRIGHTNESS_CONTROL_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en   <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= av_writedata[1];
      irq_pend <= (irq_pend & ~(wr_status & av_writedata[1])) | video_eop;
    end
  end
  assign irq = irq_pend & irq_en;
`else
  assign irq_en   = 1'b0;
  assign irq_pend = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    unique case (av_address)
      ADDR_CTRL:       rd_data[1:0] = {irq_en, ctrl_go};
      ADDR_STATUS:     rd_data[1:0] = {irq_pend, bc_enable};
      ADDR_OFFSET:     rd_data[DATA_BITS:0] = offset_shadow;
      ADDR_WIDTH:      rd_data[15:0] = video_width;
      ADDR_HEIGHT:     rd_data[15:0] = video_height;
      ADDR_INTERLACED: rd_data[3:0] = video_interlaced;
      ADDR_FRAME_CNT:  rd_data[15:0] = frame_cnt;
      default:         rd_data = '0;
    endcase
  end

endmodule
